// File: rtl/stopwatch_disp_pkg.sv
// Shared constants and types for the stopwatch 7-segment scan display.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package stopwatch_disp_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_E    = 7'h06;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef logic [2:0] digit_t;

  localparam digit_t DIG_MS_ONES  = 3'd0;
  localparam digit_t DIG_MS_TENS  = 3'd1;
  localparam digit_t DIG_SEC_ONES = 3'd2;
  localparam digit_t DIG_SEC_TENS = 3'd3;
  localparam digit_t DIG_MIN      = 3'd4;
  localparam digit_t DIG_STATUS   = 3'd5;

  typedef struct packed {
    logic       min;
    logic [7:0] sec;
    logic [7:0] ms;
    logic       timeout;
  } snap_t;

endpackage

// File: rtl/seg7_bcd_decode.sv
// BCD nibble to active-low 7-segment code.
// Values above 9 render as a dash.
module seg7_bcd_decode
  import stopwatch_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    case (bcd)
      4'd0: seg_n = SEG_DIGIT[0];
      4'd1: seg_n = SEG_DIGIT[1];
      4'd2: seg_n = SEG_DIGIT[2];
      4'd3: seg_n = SEG_DIGIT[3];
      4'd4: seg_n = SEG_DIGIT[4];
      4'd5: seg_n = SEG_DIGIT[5];
      4'd6: seg_n = SEG_DIGIT[6];
      4'd7: seg_n = SEG_DIGIT[7];
      4'd8: seg_n = SEG_DIGIT[8];
      4'd9: seg_n = SEG_DIGIT[9];
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_seg7_scan.sv
// Multiplexed 6-digit common-anode scan of the stopwatch value (M.SS.CC).
// Optional timeout blink enabled by defining SCAN_BLINK_TIMEOUT_EN.
module stopwatch_seg7_scan
  import stopwatch_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       min,
  input  logic [7:0] sec,
  input  logic [7:0] milisec,
  input  logic       timeout,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);

  if (SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_param
    $error("stopwatch_seg7_scan: SCAN_DIV>=2, BLINK_FRAMES>=1");
  end

  logic [PW-1:0] prescale;
  digit_t        idx;
  snap_t         snap;
  logic          tick;
  logic          wrap;
  logic          phase;

  assign tick = (prescale == PS_MAX);
  assign wrap = tick && (idx == DIG_STATUS);

  // Snapshot only at the frame boundary so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      idx      <= DIG_MS_ONES;
      snap     <= '0;
    end else begin
      prescale <= tick ? '0 : prescale + 1'b1;
      if (tick)
        idx <= wrap ? DIG_MS_ONES : idx + 3'd1;
      if (wrap) begin
        snap.min     <= min;
        snap.sec     <= sec;
        snap.ms      <= milisec;
        snap.timeout <= timeout;
      end
    end
  end

`ifdef SCAN_BLINK_TIMEOUT_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FR_MAX = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst || !snap.timeout) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (wrap) begin
      if (frame_cnt == FR_MAX) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  assign phase = 1'b0;
`endif

  logic [3:0] nib;
  logic [6:0] dec_seg;

  always_comb begin
    nib = 4'd0;
    unique case (idx)
      DIG_MS_ONES:  nib = snap.ms[3:0];
      DIG_MS_TENS:  nib = snap.ms[7:4];
      DIG_SEC_ONES: nib = snap.sec[3:0];
      DIG_SEC_TENS: nib = snap.sec[7:4];
      DIG_MIN:      nib = {3'b000, snap.min};
      default:      nib = 4'd0;
    endcase
  end

  seg7_bcd_decode u_dec (
    .bcd   (nib),
    .seg_n (dec_seg)
  );

  logic [6:0] seg_d;
  logic       dp_d;
  logic [5:0] an_d;

  always_comb begin
    seg_d = dec_seg;
    dp_d  = !(idx == DIG_SEC_ONES || idx == DIG_MIN);
    an_d  = ~(6'd1 << idx);
    if (idx == DIG_STATUS) begin
      dp_d = 1'b1;
      if (snap.timeout) begin
        seg_d = SEG_E;
      end else begin
        seg_d = SEG_OFF;
        an_d  = 6'h3F;
      end
    end
    if (snap.timeout && phase) begin
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      an_d  = 6'h3F;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
      an_n  <= 6'h3F;
    end else begin
      seg_n <= seg_d;
      dp_n  <= dp_d;
      an_n  <= an_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_seg7_scan.sv
// Randomized bench for stopwatch_seg7_scan against a slot/frame
// arithmetic model of the display (default build, SCAN_DIV=4).
module tb_stopwatch_seg7_scan;

  localparam int SD    = 4;
  localparam int FRAME = 6 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       min = 1'b0;
  logic [7:0] sec = 8'h00;
  logic [7:0] milisec = 8'h00;
  logic       timeout = 1'b0;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;

  stopwatch_seg7_scan #(
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .min     (min),
    .sec     (sec),
    .milisec (milisec),
    .timeout (timeout),
    .seg_n   (seg_n),
    .dp_n    (dp_n),
    .an_n    (an_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int s_min = 0;
  int s_sec = 0;
  int s_ms = 0;
  int s_to = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, k);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int v);
    logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (v > 9) return 7'h3F;
    return t[v];
  endfunction

  // Output after the k-th edge since release: slot (k-1)/SD, digit slot%6.
  function automatic logic [13:0] ref_out();
    int d;
    int v;
    logic dp;
    logic [5:0] an;
    d = ((k - 1) / SD) % 6;
    v = 0;
    case (d)
      0: v = s_ms % 16;
      1: v = s_ms / 16;
      2: v = s_sec % 16;
      3: v = s_sec / 16;
      4: v = s_min;
      default: v = 0;
    endcase
    if (d == 5)
      return s_to != 0 ? {7'h06, 1'b1, 6'h1F} : {7'h7F, 1'b1, 6'h3F};
    dp = !(d == 2 || d == 4);
    an = 6'h3F & ~(6'd1 << d);
    return {ref_seg(v), dp, an};
  endfunction

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    k++;
    check(tag, {18'd0, seg_n, dp_n, an_n}, {18'd0, ref_out()});
    if (k % FRAME == 0) begin
      s_min = int'(min);
      s_sec = int'(sec);
      s_ms  = int'(milisec);
      s_to  = int'(timeout);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("reset_dark", {18'd0, seg_n, dp_n, an_n},
            {18'd0, 7'h7F, 1'b1, 6'h3F});
    end
    rst = 1'b0;
    k = 0;
    s_min = 0;
    s_sec = 0;
    s_ms = 0;
    s_to = 0;
  endtask

  task automatic rand_inputs();
    min     = 1'($urandom_range(0, 1));
    sec     = 8'($urandom);
    milisec = 8'($urandom);
    timeout = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(3);

    min = 1'b1;
    sec = 8'h42;
    milisec = 8'h37;
    repeat (FRAME) step("frame0_zero");
    repeat (FRAME) step("m_ss_cc");

    repeat (SD + 2) step("tear_pre");
    sec = 8'h43;
    repeat (FRAME - SD - 2) step("tear_hold");
    repeat (FRAME) step("tear_next");

    milisec = 8'hA5;
    timeout = 1'b1;
    repeat (2 * FRAME) step("dash_timeout");
    timeout = 1'b0;

    repeat (600) begin
      step("rand");
      if ($urandom_range(0, 7) == 0) rand_inputs();
    end

    for (int r = 0; r < 4; r++) begin
      int guard;
      guard = 0;
      while ((k == 0 || ((k - 1) / SD) % 6 != 3 ||
              $urandom_range(0, 1) == 0) && guard < 200) begin
        step("pre_rst");
        guard++;
      end
      check("rst_reach_d3", {31'd0, guard < 200}, 32'd1);
      do_reset(1);
      repeat (2 * FRAME + int'($urandom_range(0, 30))) begin
        step("post_rst");
        if ($urandom_range(0, 5) == 0) rand_inputs();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
